// File: rtl/bus_master_port.sv
`default_nettype none
// ============================================================================
//  Module   : bus_master_port
//  Purpose  : Master-side bus interface between a core's memory-access stage
//             and the shared SoC bus. Runs one request/grant/access/ready
//             transaction per core request, stalls the core until it ends,
//             and aborts accesses that no slave answers within TIMEOUT cycles.
//  Ports    :
//    clk, reset              clock, asynchronous active-high reset
//    stall, flush            core pipeline controls
//    req, addr, rw, wr_data  core access request (rw: 1=read, 0=write)
//    rd_data, busy, err      read data, core stall, timeout-abort pulse
//    bus_req_ / bus_grnt_    bus request / grant (active-low)
//    bus_addr, bus_as_,      bus address, address strobe (active-low),
//    bus_rw, bus_wr_data     direction, write data
//    bus_rd_data, bus_rdy_   shared read data / ready (active-low) from slave mux
//  Revision : 1.0  initial release
// ============================================================================
module bus_master_port #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rw,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  // Counter value during the last permitted ACCESS cycle (counter starts at 0
  // in the first ACCESS cycle).
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_REQ    = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;
  localparam logic [1:0] c_WAIT   = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_hold;
  logic              r_err;
  logic              r_bus_req_;
  logic              r_bus_as_;
  logic              r_bus_rw;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wr_data;

  logic w_start;
  logic w_in_access;
  logic w_rdy;
  logic w_timeout;

  assign w_start     = req && !flush && !stall;
  assign w_in_access = (r_state == c_ACCESS);
  assign w_rdy       = w_in_access && !bus_rdy_;
  // Ready has priority: a timeout only fires when no ready is seen.
  assign w_timeout   = w_in_access && bus_rdy_ && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= c_IDLE;
      r_cnt         <= '0;
      r_hold        <= '0;
      r_err         <= 1'b0;
      r_bus_req_    <= 1'b1;
      r_bus_as_     <= 1'b1;
      r_bus_rw      <= 1'b1;
      r_bus_addr    <= '0;
      r_bus_wr_data <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            r_bus_addr    <= addr;
            r_bus_rw      <= rw;
            r_bus_wr_data <= wr_data;
            r_bus_req_    <= 1'b0;
            r_state       <= c_REQ;
          end
        end
        c_REQ: begin
          if (!bus_grnt_) begin
            r_bus_as_ <= 1'b0;
            r_cnt     <= '0;
            r_state   <= c_ACCESS;
          end
        end
        c_ACCESS: begin
          // Strobe lasts only the first ACCESS cycle.
          r_bus_as_ <= 1'b1;
          if (w_rdy) begin
            if (r_bus_rw) begin
              r_hold <= bus_rd_data;
            end
            r_bus_req_ <= 1'b1;
            r_cnt      <= '0;
            r_state    <= stall ? c_WAIT : c_IDLE;
          end else if (w_timeout) begin
            r_err      <= 1'b1;
            r_hold     <= '0;
            r_bus_req_ <= 1'b1;
            r_cnt      <= '0;
            r_state    <= stall ? c_WAIT : c_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        c_WAIT: begin
          if (!stall) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    busy = 1'b0;
    case (r_state)
      c_IDLE:   busy = w_start;
      c_REQ:    busy = 1'b1;
      c_ACCESS: busy = bus_rdy_ && !w_timeout;
      default:  busy = 1'b0;
    endcase
  end

  // Zero-latency pass-through on the ready cycle, buffered value otherwise.
  assign rd_data     = w_rdy ? bus_rd_data : r_hold;
  assign err         = r_err;
  assign bus_req_    = r_bus_req_;
  assign bus_as_     = r_bus_as_;
  assign bus_rw      = r_bus_rw;
  assign bus_addr    = r_bus_addr;
  assign bus_wr_data = r_bus_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_master_port
//  Purpose  : Directed self-checking bench for bus_master_port (TIMEOUT=8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_bus_master_port;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk;
  logic              reset;
  logic              stall;
  logic              flush;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              rw;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              err;
  logic              bus_req_;
  logic              bus_grnt_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;

  int n_cmp = 0;
  int n_bad = 0;

  bus_master_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .req        (req),
    .addr       (addr),
    .rw         (rw),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .busy       (busy),
    .err        (err),
    .bus_req_   (bus_req_),
    .bus_grnt_  (bus_grnt_),
    .bus_addr   (bus_addr),
    .bus_as_    (bus_as_),
    .bus_rw     (bus_rw),
    .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data),
    .bus_rdy_   (bus_rdy_)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge; inputs are changed there and
  // outputs are checked a further 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; req = 1'b0; addr = '0; rw = 1'b1;
    wr_data = '0; bus_grnt_ = 1'b1; bus_rd_data = '0; bus_rdy_ = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (bus_req_ !== 1'b1) begin n_bad++; $display("FAIL rst_bus_req_: got %b want 1", bus_req_); end
    n_cmp++; if (bus_as_ !== 1'b1) begin n_bad++; $display("FAIL rst_bus_as_: got %b want 1", bus_as_); end
    n_cmp++; if (bus_rw !== 1'b1) begin n_bad++; $display("FAIL rst_bus_rw: got %b want 1", bus_rw); end
    n_cmp++; if (bus_addr !== 30'h0) begin n_bad++; $display("FAIL rst_bus_addr: got %h want 0", bus_addr); end
    n_cmp++; if (bus_wr_data !== 32'h0) begin n_bad++; $display("FAIL rst_bus_wr_data: got %h want 0", bus_wr_data); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (rd_data !== 32'h0) begin n_bad++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
  endtask

  // T1: grant after two REQ cycles, ready on ACCESS cycle 3.
  task automatic test_read();
    tick();
    req = 1'b1; rw = 1'b1; addr = 30'h100;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy_idle: got %b want 1", busy); end
    tick();  // REQ cycle 1
    req = 1'b0;
    #1;
    n_cmp++; if (bus_req_ !== 1'b0) begin n_bad++; $display("FAIL rd_bus_req_: got %b want 0", bus_req_); end
    n_cmp++; if (bus_addr !== 30'h100) begin n_bad++; $display("FAIL rd_bus_addr: got %h want 100", bus_addr); end
    n_cmp++; if (bus_as_ !== 1'b1) begin n_bad++; $display("FAIL rd_as_req1: got %b want 1", bus_as_); end
    tick();  // REQ cycle 2
    bus_grnt_ = 1'b0;
    #1;
    n_cmp++; if (bus_as_ !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rd_req2: as=%b busy=%b want 1 1", bus_as_, busy); end
    tick();  // ACCESS cycle 1
    bus_grnt_ = 1'b1;
    #1;
    n_cmp++; if (bus_as_ !== 1'b0) begin n_bad++; $display("FAIL rd_as_acc1: got %b want 0", bus_as_); end
    tick();  // ACCESS cycle 2
    #1;
    n_cmp++; if (bus_as_ !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rd_acc2: as=%b busy=%b want 1 1", bus_as_, busy); end
    tick();  // ACCESS cycle 3
    bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_rdy: got %b want 0", busy); end
    n_cmp++; if (rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_passthru: got %h want deadbeef", rd_data); end
    tick();  // IDLE
    bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
    #1;
    n_cmp++; if (rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_hold: got %h want deadbeef", rd_data); end
    n_cmp++; if (bus_req_ !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rd_idle: req_=%b busy=%b want 1 0", bus_req_, busy); end
  endtask

  // T2: write with immediate grant and ready.
  task automatic test_write();
    req = 1'b1; rw = 1'b0; addr = 30'h200; wr_data = 32'h12345678; bus_grnt_ = 1'b0;
    tick();  // REQ
    req = 1'b0;
    tick();  // ACCESS 1
    #1;
    n_cmp++; if (bus_as_ !== 1'b0 || bus_rw !== 1'b0) begin n_bad++; $display("FAIL wr_as_rw: as=%b rw=%b want 0 0", bus_as_, bus_rw); end
    n_cmp++; if (bus_wr_data !== 32'h12345678) begin n_bad++; $display("FAIL wr_data: got %h want 12345678", bus_wr_data); end
    bus_rdy_ = 1'b0; bus_rd_data = 32'hFFFFFFFF;
    tick();  // IDLE
    bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; bus_rd_data = 32'h0;
    #1;
    n_cmp++; if (rd_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_hold_kept: got %h want deadbeef", rd_data); end
    n_cmp++; if (err !== 1'b0 || bus_req_ !== 1'b1) begin n_bad++; $display("FAIL wr_end: err=%b req_=%b want 0 1", err, bus_req_); end
  endtask

  // T3: read completes under stall, result held in WAIT.
  task automatic test_stall_hold();
    req = 1'b1; rw = 1'b1; addr = 30'h300; bus_grnt_ = 1'b0;
    tick();  // REQ
    req = 1'b0;
    tick();  // ACCESS 1
    bus_grnt_ = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hA5A5A5A5; stall = 1'b1;
    tick();  // WAIT
    bus_rdy_ = 1'b1; bus_rd_data = 32'h0; req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (busy !== 1'b0 || rd_data !== 32'hA5A5A5A5 || bus_req_ !== 1'b1) begin
        n_bad++;
        $display("FAIL stall_wait%0d: busy=%b rd=%h req_=%b want 0 a5a5a5a5 1", i, busy, rd_data, bus_req_);
      end
      if (i < 3) tick();
    end
    stall = 1'b0; req = 1'b0;
    tick();  // IDLE
    req = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL stall_idle_after: busy got %b want 1", busy); end
    req = 1'b0;
    #1;
  endtask

  // T4: timeout abort on ACCESS cycle 8, then ready exactly on cycle 8.
  task automatic test_timeout();
    req = 1'b1; rw = 1'b1; addr = 30'h400; bus_grnt_ = 1'b0;
    tick();  // REQ
    req = 1'b0;
    tick();  // ACCESS 1
    bus_grnt_ = 1'b1;
    for (int c = 1; c < TIMEOUT; c++) begin
      #1;
      n_cmp++; if (busy !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL to_acc%0d: busy=%b err=%b want 1 0", c, busy, err); end
      tick();
    end
    #1;  // ACCESS cycle 8
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_busy_last: got %b want 0", busy); end
    tick();  // IDLE
    #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL to_err: got %b want 1", err); end
    n_cmp++; if (rd_data !== 32'h0 || bus_req_ !== 1'b1) begin n_bad++; $display("FAIL to_abort: rd=%h req_=%b want 0 1", rd_data, bus_req_); end
    tick();
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL to_err_pulse: got %b want 0", err); end

    req = 1'b1; addr = 30'h404; bus_grnt_ = 1'b0;
    tick();  // REQ
    req = 1'b0;
    tick();  // ACCESS 1
    bus_grnt_ = 1'b1;
    repeat (TIMEOUT - 1) tick();  // ACCESS 8
    bus_rdy_ = 1'b0; bus_rd_data = 32'h55AA55AA;
    tick();  // IDLE
    bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
    #1;
    n_cmp++; if (err !== 1'b0 || rd_data !== 32'h55AA55AA) begin n_bad++; $display("FAIL to_rdy_wins: err=%b rd=%h want 0 55aa55aa", err, rd_data); end
  endtask

  // T5: flush blocks a request in IDLE, but not one already on the bus.
  task automatic test_flush();
    req = 1'b1; flush = 1'b1; rw = 1'b1; addr = 30'h500;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fl_busy: got %b want 0", busy); end
    tick();
    #1;
    n_cmp++; if (bus_req_ !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL fl_blocked: req_=%b busy=%b want 1 0", bus_req_, busy); end
    flush = 1'b0; bus_grnt_ = 1'b0;
    tick();  // REQ
    req = 1'b0;
    tick();  // ACCESS 1
    bus_grnt_ = 1'b1; flush = 1'b1;
    tick();  // ACCESS 2
    #1;
    n_cmp++; if (busy !== 1'b1 || bus_req_ !== 1'b0) begin n_bad++; $display("FAIL fl_in_access: busy=%b req_=%b want 1 0", busy, bus_req_); end
    bus_rdy_ = 1'b0; bus_rd_data = 32'h0F0F0F0F;
    tick();  // IDLE
    bus_rdy_ = 1'b1; bus_rd_data = 32'h0; flush = 1'b0;
    #1;
    n_cmp++; if (rd_data !== 32'h0F0F0F0F) begin n_bad++; $display("FAIL fl_completed: got %h want 0f0f0f0f", rd_data); end
  endtask

  // T6: asynchronous reset while the strobe is active.
  task automatic test_reset_mid_access();
    req = 1'b1; rw = 1'b1; addr = 30'h600; bus_grnt_ = 1'b0;
    tick();  // REQ
    req = 1'b0;
    tick();  // ACCESS 1
    bus_grnt_ = 1'b1;
    #1;
    n_cmp++; if (bus_as_ !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL rm_pre: as=%b busy=%b want 0 1", bus_as_, busy); end
    reset = 1'b1;
    #1;  // still well before the next edge
    n_cmp++;
    if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_async: req_=%b as=%b busy=%b err=%b want 1 1 0 0", bus_req_, bus_as_, busy, err);
    end
    tick();
    reset = 1'b0;
    req = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b1 || rd_data !== 32'h0) begin n_bad++; $display("FAIL rm_idle: busy=%b rd=%h want 1 0", busy, rd_data); end
    req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_stall_hold();
    test_timeout();
    test_flush();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
